// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx: streams registers 0..NUM_REGS-1 read over SA/A as 8N1 serial frames on tx.
// Defining REGDUMP_PARITY_EN inserts an even-parity bit (8E1 frames).
module regfile_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [2:0] SA,
  input  logic [7:0] A,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE, SEL, START, DATA,
`ifdef REGDUMP_PARITY_EN
    PAR,
`endif
    STOP, DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
`ifdef REGDUMP_PARITY_EN
  logic            par_q;
`endif
  logic            baud_wrap;
  logic            framing;
  logic            last;

  assign baud_wrap = baud_q == BW'(CLKS_PER_BIT - 1);
  assign framing   = state_q != IDLE && state_q != SEL && state_q != DONE;
  assign last      = idx_q == 3'(NUM_REGS - 1);
  assign SA        = idx_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGDUMP_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      baud_q <= (framing && !baud_wrap) ? baud_q + 1'b1 : '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SEL;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
        SEL: begin
          sh_q    <= A;
`ifdef REGDUMP_PARITY_EN
          par_q   <= ^A;
`endif
          tx_q    <= 1'b0;
          state_q <= START;
        end
        START: if (baud_wrap) begin
          state_q <= DATA;
          bit_q   <= '0;
          tx_q    <= sh_q[0];
        end
        DATA: if (baud_wrap) begin
          if (bit_q == 3'd7) begin
`ifdef REGDUMP_PARITY_EN
            state_q <= PAR;
            tx_q    <= par_q;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            bit_q <= bit_q + 1'b1;
            sh_q  <= sh_q >> 1;
            tx_q  <= sh_q[1];
          end
        end
`ifdef REGDUMP_PARITY_EN
        PAR: if (baud_wrap) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: if (baud_wrap) begin
          // idx clears on the way into DONE so SA reads 0 once idle again
          state_q <= last ? DONE : SEL;
          idx_q   <= last ? 3'd0 : idx_q + 1'b1;
          done_q  <= last;
          busy_q  <= !last;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
